// File: rtl/riscv_str_ops_issue.sv
// EX-stage initiator for the riscv_str_ops unit: request latch, multicycle hold, writeback handshake, flush drain.
// Optional watchdog abort enabled by defining STR_OPS_TIMEOUT_EN.
module riscv_str_ops_issue #(
  parameter int unsigned STR_OP_WIDTH   = 2,
  parameter int unsigned RD_WIDTH       = 5,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [STR_OP_WIDTH-1:0] req_op_i,
  input  logic [31:0]             req_operand_i,
  input  logic [RD_WIDTH-1:0]     req_rd_i,
  output logic                    str_enable_o,
  output logic [STR_OP_WIDTH-1:0] str_operator_o,
  output logic [31:0]             str_operand_o,
  input  logic [31:0]             str_result_i,
  input  logic                    str_ready_i,
  output logic                    str_ex_ready_o,
  output logic                    wb_valid_o,
  input  logic                    wb_ready_i,
  output logic [RD_WIDTH-1:0]     wb_rd_o,
  output logic [31:0]             wb_result_o,
  output logic                    busy_o,
  output logic                    error_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_e;

  state_e                  state_q;
  logic [STR_OP_WIDTH-1:0] op_q;
  logic [31:0]             operand_q;
  logic [RD_WIDTH-1:0]     rd_q;
  logic [31:0]             result_q;
  logic                    in_unit;
  logic                    accept;

`ifdef STR_OPS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             timeout;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !str_ready_i;
  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif

  assign in_unit        = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign accept         = !flush_i &&
                          ((state_q == S_IDLE) || ((state_q == S_RESP) && wb_ready_i));
  assign req_ready_o    = accept;
  assign str_enable_o   = in_unit;
  assign str_ex_ready_o = (in_unit && str_ready_i && !flush_i) || (state_q == S_DRAIN);
  assign str_operator_o = op_q;
  assign str_operand_o  = operand_q;
  assign wb_valid_o     = (state_q == S_RESP) && !flush_i;
  assign wb_rd_o        = rd_q;
  assign wb_result_o    = result_q;
  assign busy_o         = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      operand_q <= '0;
      rd_q      <= '0;
      result_q  <= '0;
`ifdef STR_OPS_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
`ifdef STR_OPS_TIMEOUT_EN
      err_q <= 1'b0;
      // Held at zero outside WAIT/DRAIN (ISSUE always precedes WAIT), and on WAIT->DRAIN.
      if ((state_q == S_WAIT && !flush_i) || state_q == S_DRAIN) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
`endif
      unique case (state_q)
        S_IDLE: begin
          if (req_valid_i && !flush_i) begin
            op_q      <= req_op_i;
            operand_q <= req_operand_i;
            rd_q      <= req_rd_i;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (flush_i) begin
            state_q <= S_DRAIN;
          end else if (str_ready_i) begin
            result_q <= str_result_i;
            state_q  <= S_RESP;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush_i) begin
            state_q <= S_DRAIN;
          end else if (str_ready_i) begin
            result_q <= str_result_i;
            state_q  <= S_RESP;
          end
`ifdef STR_OPS_TIMEOUT_EN
          else if (timeout) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end
`endif
        end
        S_RESP: begin
          if (flush_i) begin
            state_q <= S_IDLE;
          end else if (wb_ready_i) begin
            if (req_valid_i) begin
              op_q      <= req_op_i;
              operand_q <= req_operand_i;
              rd_q      <= req_rd_i;
              state_q   <= S_ISSUE;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_DRAIN: begin
          if (str_ready_i) begin
            state_q <= S_IDLE;
          end
`ifdef STR_OPS_TIMEOUT_EN
          else if (timeout) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_str_ops_issue.sv
// Directed bench for riscv_str_ops_issue with a behavioural string-op unit (UPPER=0, LOWER=1, LEET=2, ROT13=3).
module tb_riscv_str_ops_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic [31:0] req_operand_i;
  logic [4:0]  req_rd_i;
  logic        str_enable_o;
  logic [1:0]  str_operator_o;
  logic [31:0] str_operand_o;
  logic [31:0] str_result_i;
  logic        str_ready_i;
  logic        str_ex_ready_o;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_result_o;
  logic        busy_o;
  logic        error_o;
  logic        force_nr = 1'b0;

  int errors = 0;
  int checks = 0;

  riscv_str_ops_issue #(.STR_OP_WIDTH(2), .RD_WIDTH(5), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_operand_i(req_operand_i), .req_rd_i(req_rd_i),
    .str_enable_o(str_enable_o), .str_operator_o(str_operator_o), .str_operand_o(str_operand_o),
    .str_result_i(str_result_i), .str_ready_i(str_ready_i), .str_ex_ready_o(str_ex_ready_o),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o),
    .wb_result_o(wb_result_o), .busy_o(busy_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Unit stand-in: LEET takes 5 enabled cycles, others 1; keeps running when enable drops,
  // holds ready until ex_ready.
  logic [3:0] u_cnt, u_cur;
  logic       u_active;

  function automatic logic [7:0] f_byte(input logic [1:0] op, input logic [7:0] c);
    logic lc, uc;
    lc = (c >= 8'h61) && (c <= 8'h7A);
    uc = (c >= 8'h41) && (c <= 8'h5A);
    case (op)
      2'd0: return lc ? c - 8'h20 : c;
      2'd1: return uc ? c + 8'h20 : c;
      2'd2: begin
        case (c)
          8'h61: return 8'h34;
          8'h65: return 8'h33;
          8'h6C: return 8'h31;
          8'h6F: return 8'h30;
          8'h73: return 8'h35;
          8'h74: return 8'h37;
          default: return c;
        endcase
      end
      default: begin
        if (lc) return ((c - 8'h61 + 8'd13) % 8'd26) + 8'h61;
        if (uc) return ((c - 8'h41 + 8'd13) % 8'd26) + 8'h41;
        return c;
      end
    endcase
  endfunction

  always_comb begin
    u_cur = u_active ? u_cnt : (str_enable_o ? 4'd1 : 4'd0);
    str_ready_i = !force_nr && (u_cur != 4'd0) &&
                  (u_cur >= ((str_operator_o == 2'd2) ? 4'd5 : 4'd1));
    str_result_i = '0;
    for (int unsigned i = 0; i < 4; i++) str_result_i[8*i +: 8] = f_byte(str_operator_o, str_operand_o[8*i +: 8]);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_active <= 1'b0;
      u_cnt    <= 4'd0;
    end else if (u_cur != 4'd0) begin
      if (str_ready_i && str_ex_ready_o) begin
        u_active <= 1'b0;
        u_cnt    <= 4'd0;
      end else begin
        u_active <= 1'b1;
        u_cnt    <= (u_cur < 4'd15) ? u_cur + 4'd1 : u_cur;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] op, input logic [31:0] opnd, input logic [4:0] rd);
    req_valid_i   = 1'b1;
    req_op_i      = op;
    req_operand_i = opnd;
    req_rd_i      = rd;
  endtask

  task automatic run_simple(input logic [1:0] op, input logic [31:0] opnd, input logic [4:0] rd,
                            input logic [31:0] exp_res);
    wb_ready_i = 1'b1;
    req(op, opnd, rd);
    @(negedge clk);
    chk("simple_accept", req_ready_o, 1'b1);
    tick();
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("simple_issue_en", str_enable_o, 1'b1);
    tick();
    @(negedge clk);
    chk("simple_wb_valid", wb_valid_o, 1'b1);
    chk("simple_wb_result", wb_result_o, exp_res);
    chk("simple_wb_rd", wb_rd_o, rd);
    tick();
  endtask

  int en_cnt, exr_cnt, exr_cyc, wbv_cyc, idle_cyc, wbv_seen, err_cnt, err_cyc;
  logic [31:0] res_seen;

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; req_op_i = '0;
    req_operand_i = '0; req_rd_i = '0; wb_ready_i = 1'b0;

    @(negedge clk);
    chk("rst_req_ready", req_ready_o, 1'b1);
    chk("rst_wb_valid", wb_valid_o, 1'b0);
    chk("rst_enable", str_enable_o, 1'b0);
    chk("rst_ex_ready", str_ex_ready_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_error", error_o, 1'b0);
    chk("rst_wb_result", wb_result_o, 32'h0);
    chk("rst_operand", str_operand_o, 32'h0);
    rst_n = 1'b1;
    tick();

    wb_ready_i = 1'b1;
    req(2'd0, 32'h64636261, 5'd5);
    @(negedge clk);
    chk("up_req_ready", req_ready_o, 1'b1);
    tick();
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("up_enable", str_enable_o, 1'b1);
    chk("up_ex_ready", str_ex_ready_o, 1'b1);
    chk("up_operand", str_operand_o, 32'h64636261);
    chk("up_wb_early", wb_valid_o, 1'b0);
    tick();
    @(negedge clk);
    chk("up_wb_valid", wb_valid_o, 1'b1);
    chk("up_wb_result", wb_result_o, 32'h44434241);
    chk("up_wb_rd", wb_rd_o, 5'd5);
    tick();
    @(negedge clk);
    chk("up_idle", busy_o, 1'b0);
    tick();

    req(2'd2, 32'h6C656574, 5'd7);
    @(negedge clk);
    tick();
    req_valid_i = 1'b0;
    en_cnt = 0; exr_cnt = 0; exr_cyc = 0; wbv_cyc = 0; res_seen = '0;
    for (int unsigned c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (str_enable_o) en_cnt++;
      if (str_ex_ready_o) begin exr_cnt++; exr_cyc = c; end
      if (wb_valid_o && wbv_cyc == 0) begin wbv_cyc = c; res_seen = wb_result_o; end
      tick();
    end
    chk("leet_enable_cycles", en_cnt, 5);
    chk("leet_ex_ready_pulses", exr_cnt, 1);
    chk("leet_ex_ready_cycle", exr_cyc, 5);
    chk("leet_wb_cycle", wbv_cyc, 6);
    chk("leet_result", res_seen, 32'h31333337);

    wb_ready_i = 1'b0;
    req(2'd0, 32'h6F6C6C65, 5'd9);
    @(negedge clk);
    tick();
    req(2'd1, 32'h44434241, 5'd3);
    @(negedge clk);
    tick();
    for (int unsigned c = 2; c <= 5; c++) begin
      @(negedge clk);
      chk("stall_wb_valid", wb_valid_o, 1'b1);
      chk("stall_wb_result", wb_result_o, 32'h4F4C4C45);
      chk("stall_wb_rd", wb_rd_o, 5'd9);
      chk("stall_req_ready", req_ready_o, 1'b0);
      tick();
    end
    wb_ready_i = 1'b1;
    @(negedge clk);
    chk("b2b_req_ready", req_ready_o, 1'b1);
    chk("b2b_wb_valid", wb_valid_o, 1'b1);
    tick();
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("b2b_operator", str_operator_o, 2'd1);
    chk("b2b_operand", str_operand_o, 32'h44434241);
    chk("b2b_enable", str_enable_o, 1'b1);
    tick();
    @(negedge clk);
    chk("b2b_wb_valid2", wb_valid_o, 1'b1);
    chk("b2b_wb_result", wb_result_o, 32'h64636261);
    chk("b2b_wb_rd", wb_rd_o, 5'd3);
    tick();

    req(2'd2, 32'h6C656574, 5'd4);
    @(negedge clk);
    tick();
    req_valid_i = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    flush_i = 1'b1;
    @(negedge clk);
    chk("fl_ex_ready", str_ex_ready_o, 1'b0);
    chk("fl_wb_valid", wb_valid_o, 1'b0);
    tick();
    flush_i = 1'b0;
    @(negedge clk);
    chk("drain_enable", str_enable_o, 1'b0);
    chk("drain_ex_ready", str_ex_ready_o, 1'b1);
    chk("drain_busy", busy_o, 1'b1);
    tick();
    idle_cyc = 0; wbv_seen = 0;
    for (int unsigned c = 5; c <= 12; c++) begin
      @(negedge clk);
      if (wb_valid_o) wbv_seen++;
      if (!busy_o && idle_cyc == 0) idle_cyc = c;
      tick();
    end
    chk("drain_exit_cycle", idle_cyc, 6);
    chk("drain_no_wb", wbv_seen, 0);
    run_simple(2'd0, 32'h7A7A7A7A, 5'd1, 32'h5A5A5A5A);

    run_simple(2'd3, 32'h6E6F6261, 5'd2, 32'h61626F6E);
    run_simple(2'd1, 32'h5A2D4241, 5'd31, 32'h7A2D6261);

    flush_i = 1'b1;
    req(2'd0, 32'h61616161, 5'd6);
    @(negedge clk);
    chk("idle_flush_req_ready", req_ready_o, 1'b0);
    tick();
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("idle_flush_busy", busy_o, 1'b0);
    tick();

    wb_ready_i = 1'b0;
    req(2'd0, 32'h61616161, 5'd6);
    @(negedge clk);
    tick();
    req_valid_i = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("resp_wb_valid", wb_valid_o, 1'b1);
    tick();
    flush_i = 1'b1;
    @(negedge clk);
    chk("resp_flush_wb_valid", wb_valid_o, 1'b0);
    tick();
    flush_i = 1'b0;
    @(negedge clk);
    chk("resp_flush_busy", busy_o, 1'b0);
    chk("resp_flush_wb_after", wb_valid_o, 1'b0);
    tick();

`ifdef STR_OPS_TIMEOUT_EN
    wb_ready_i = 1'b1;
    force_nr = 1'b1;
    req(2'd0, 32'h61616161, 5'd10);
    @(negedge clk);
    tick();
    req_valid_i = 1'b0;
    err_cnt = 0; err_cyc = 0; wbv_seen = 0;
    for (int unsigned c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (error_o) begin
        err_cnt++;
        if (err_cyc == 0) err_cyc = c;
      end
      if (wb_valid_o) wbv_seen++;
      tick();
    end
    chk("to_error_pulses", err_cnt, 1);
    chk("to_error_cycle", err_cyc, 18);
    chk("to_no_wb", wbv_seen, 0);
    chk("to_idle", busy_o, 1'b0);
    force_nr = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
`endif

    wb_ready_i = 1'b1;
    req(2'd2, 32'h6C656574, 5'd8);
    @(negedge clk);
    tick();
    req_valid_i = 1'b0;
    @(negedge clk);
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_enable", str_enable_o, 1'b0);
    chk("arst_wb_result", wb_result_o, 32'h0);
    @(negedge clk);
    chk("arst_wb_valid", wb_valid_o, 1'b0);
    rst_n = 1'b1;
    tick();
    run_simple(2'd0, 32'h64636261, 5'd5, 32'h44434241);
    chk("final_error", error_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
